// File: rtl/pmod_i2s2_pkg.sv
// Shared constants and slot helpers for the Pmod I2S2 master.
package pmod_i2s2_pkg;

  localparam int DATA_W   = 24;
  localparam int CNT_W    = 11;
  localparam int MCLK_BIT = 2;
  localparam int SCLK_BIT = 4;
  localparam int LRCK_BIT = 10;
  localparam int SLOT_MSB = 9;
  localparam int SLOT_LSB = 5;
  localparam int SLOT_W   = SLOT_MSB - SLOT_LSB + 1;
  localparam int PHASE_W  = SCLK_BIT + 1;

  localparam logic [SLOT_W-1:0]  FIRST_DATA_SLOT = 5'd1;
  localparam logic [SLOT_W-1:0]  LAST_DATA_SLOT  = 5'd24;
  localparam logic [CNT_W-1:0]   FRAME_LAST      = 11'd2047;
  // sclk has been high for one clk: stable point to sample ADC data
  localparam logic [PHASE_W-1:0] PHASE_SAMPLE    = 5'd16;
  // last clk of a slot: next edge drops sclk and starts the next slot
  localparam logic [PHASE_W-1:0] PHASE_LAST      = 5'd31;

  // True for slots carrying sample bits (slot 0 is the I2S delay bit)
  function automatic logic is_data_slot(input logic [SLOT_W-1:0] s);
    return (s >= FIRST_DATA_SLOT) && (s <= LAST_DATA_SLOT);
  endfunction

  // Sample bit carried by a data slot, MSB first
  function automatic logic [SLOT_W-1:0] bit_index(input logic [SLOT_W-1:0] s);
    return LAST_DATA_SLOT - s;
  endfunction

endpackage

// File: rtl/pmod_i2s2_clkgen.sv
// Free-running frame counter: codec clocks and slot/phase decode.
module pmod_i2s2_clkgen
  import pmod_i2s2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              mclk,
  output logic              sclk,
  output logic              lrck,
  output logic [SLOT_W-1:0] slot,
  output logic              sample_en,
  output logic              shift_en,
  output logic              frame_end
);

  logic [CNT_W-1:0] cnt;

  // Frame counter; all clock outputs are straight flop bits of it
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt + 1'b1;
  end

  assign mclk      = cnt[MCLK_BIT];
  assign sclk      = cnt[SCLK_BIT];
  assign lrck      = cnt[LRCK_BIT];
  assign slot      = cnt[SLOT_MSB:SLOT_LSB];
  assign sample_en = (cnt[SCLK_BIT:0] == PHASE_SAMPLE);
  assign shift_en  = (cnt[SCLK_BIT:0] == PHASE_LAST);
  assign frame_end = (cnt == FRAME_LAST);

endmodule

// File: rtl/pmod_i2s2.sv
// I2S master for the Pmod I2S2: 24-bit stereo DAC out, ADC in, frame strobe.
module pmod_i2s2
  import pmod_i2s2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              mclk,
  output logic              lrck,
  output logic              sclk,
  input  logic [DATA_W-1:0] dac_l,
  input  logic [DATA_W-1:0] dac_r,
  output logic              dac_sdata,
  input  logic              adc_sdata,
  output logic [DATA_W-1:0] adc_l,
  output logic [DATA_W-1:0] adc_r,
  output logic              dac_rd_adc_wr
);

  logic [SLOT_W-1:0] slot;
  logic              sample_en;
  logic              shift_en;
  logic              frame_end;
  logic [SLOT_W-1:0] next_slot;
  logic              next_half;
  logic [DATA_W-1:0] cap_l, cap_r;
  logic [DATA_W-1:0] lat_l, lat_r;

  pmod_i2s2_clkgen u_clkgen (
    .clk       (clk),
    .rst       (rst),
    .mclk      (mclk),
    .sclk      (sclk),
    .lrck      (lrck),
    .slot      (slot),
    .sample_en (sample_en),
    .shift_en  (shift_en),
    .frame_end (frame_end)
  );

  // dac_sdata is loaded one clk ahead, so decode the slot about to start
  assign next_slot     = slot + 5'd1;
  assign next_half     = (next_slot == '0) ? ~lrck : lrck;
  assign dac_rd_adc_wr = frame_end;

  // DAC shifter: present the next slot's bit as sclk falls
  always_ff @(posedge clk) begin
    if (!rst) begin
      dac_sdata <= 1'b0;
    end else if (shift_en) begin
      if (is_data_slot(next_slot))
        dac_sdata <= next_half ? lat_r[bit_index(next_slot)]
                               : lat_l[bit_index(next_slot)];
      else
        dac_sdata <= 1'b0;
    end
  end

  // ADC capture: sample mid-high of sclk into the current channel
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_l <= '0;
      cap_r <= '0;
    end else if (sample_en && is_data_slot(slot)) begin
      if (lrck) cap_r[bit_index(slot)] <= adc_sdata;
      else      cap_l[bit_index(slot)] <= adc_sdata;
    end
  end

  // Frame exchange: publish captured ADC pair, latch next DAC pair
  always_ff @(posedge clk) begin
    if (!rst) begin
      adc_l <= '0;
      adc_r <= '0;
      lat_l <= '0;
      lat_r <= '0;
    end else if (frame_end) begin
      adc_l <= cap_l;
      adc_r <= cap_r;
      lat_l <= dac_l;
      lat_r <= dac_r;
    end
  end

endmodule

// File: tb/tb_pmod_i2s2.sv
// Self-checking bench: behavioural I2S codec model plus frame scoreboards.
module tb_pmod_i2s2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] dac_l = '0;
  logic [23:0] dac_r = '0;
  logic        adc_sdata = 1'b0;
  logic        mclk, lrck, sclk, dac_sdata, dac_rd_adc_wr;
  logic [23:0] adc_l, adc_r;

  int n_cmp = 0;
  int n_err = 0;

  int adc_mode = 0;   // 0 random, 1 0x555555/0x123456, 2 0xA5A5A5/0x5A5A5A
  int dac_mode = 0;   // 0 random every clk, 1 FFFFFF/000000, 2 loopback

  logic [47:0] adc_q[$];
  logic [47:0] dac_q[$];

  int          bitpos = 0;
  logic        prev_lr = 1'b0;
  logic [23:0] cur_l = '0, cur_r = '0;
  logic [23:0] rx_l = '0, rx_r = '0;
  longint      last_strobe = 0;

  always #5 clk = ~clk;

  pmod_i2s2 dut (
    .clk           (clk),
    .rst           (rst),
    .mclk          (mclk),
    .lrck          (lrck),
    .sclk          (sclk),
    .dac_l         (dac_l),
    .dac_r         (dac_r),
    .dac_sdata     (dac_sdata),
    .adc_sdata     (adc_sdata),
    .adc_l         (adc_l),
    .adc_r         (adc_r),
    .dac_rd_adc_wr (dac_rd_adc_wr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: expectation queue empty at %0t", name, $time);
  endtask

  // Pick the words the codec sends this frame and expect them at its strobe
  task automatic start_frame();
    case (adc_mode)
      1: begin cur_l = 24'h555555; cur_r = 24'h123456; end
      2: begin cur_l = 24'hA5A5A5; cur_r = 24'h5A5A5A; end
      default: begin cur_l = 24'($urandom); cur_r = 24'($urandom); end
    endcase
    adc_q.push_back({cur_l, cur_r});
  endtask

  // Reset release: a new frame starts, and the first DAC frame is all zero
  task automatic model_start();
    adc_q.delete();
    dac_q.delete();
    dac_q.push_back(48'd0);
    bitpos      = 0;
    prev_lr     = 1'b0;
    last_strobe = 0;
    start_frame();
  endtask

  task automatic finish_rx();
    logic [47:0] e;
    if (dac_q.size() == 0) begin
      miss("dac_frame");
    end else begin
      e = dac_q.pop_front();
      chk("dac_left_word",  32'(rx_l), 32'(e[47:24]));
      chk("dac_right_word", 32'(rx_r), 32'(e[23:0]));
    end
  endtask

  // Codec transmit side: one-bit-delayed I2S, MSB first, junk after LSB
  initial forever begin
    @(negedge sclk);
    #1;
    if (rst) begin
      if (lrck !== prev_lr) begin
        bitpos  = 0;
        prev_lr = lrck;
        if (!lrck) begin
          finish_rx();
          start_frame();
        end
      end else begin
        bitpos++;
      end
      if (bitpos >= 1 && bitpos <= 24)
        adc_sdata = prev_lr ? cur_r[24-bitpos] : cur_l[24-bitpos];
      else
        adc_sdata = 1'($urandom);
    end
  end

  // Codec receive side: latch dac_sdata on sclk rising
  initial forever begin
    @(posedge sclk);
    #1;
    if (rst) begin
      if (bitpos >= 1 && bitpos <= 24) begin
        if (lrck) rx_r[24-bitpos] = dac_sdata;
        else      rx_l[24-bitpos] = dac_sdata;
      end else begin
        chk("dac_idle_bit", 32'(dac_sdata), 32'd0);
      end
    end
  end

  // User-side driver: DAC words change every clk unless held or looped back
  initial forever begin
    @(negedge clk);
    case (dac_mode)
      1: begin dac_l = 24'hFFFFFF; dac_r = 24'h000000; end
      2: begin dac_l = adc_l;      dac_r = adc_r;      end
      default: begin dac_l = 24'($urandom); dac_r = 24'($urandom); end
    endcase
    if (rst && dac_rd_adc_wr === 1'b1) dac_q.push_back({dac_l, dac_r});
  end

  // Strobe monitor: period, width and ADC pair published at the strobe
  initial forever begin
    logic [47:0] e;
    logic        have;
    @(negedge clk);
    if (rst && dac_rd_adc_wr === 1'b1) begin
      if (last_strobe != 0) chk("strobe_period", 32'($time - last_strobe), 32'd20480);
      last_strobe = $time;
      have = (adc_q.size() != 0);
      if (have) e = adc_q.pop_front();
      else      miss("adc_frame");
      @(posedge clk);
      #1;
      if (have) begin
        chk("adc_l", 32'(adc_l), 32'(e[47:24]));
        chk("adc_r", 32'(adc_r), 32'(e[23:0]));
      end
      @(negedge clk);
      chk("strobe_width", 32'(dac_rd_adc_wr), 32'd0);
    end
  end

  initial begin
    int     n;
    longint t0;

    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mclk",   32'(mclk),          32'd0);
    chk("rst_sclk",   32'(sclk),          32'd0);
    chk("rst_lrck",   32'(lrck),          32'd0);
    chk("rst_sdata",  32'(dac_sdata),     32'd0);
    chk("rst_adc_l",  32'(adc_l),         32'd0);
    chk("rst_adc_r",  32'(adc_r),         32'd0);
    chk("rst_strobe", 32'(dac_rd_adc_wr), 32'd0);

    adc_mode = 1;
    dac_mode = 1;
    rst = 1'b1;
    model_start();

    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      n++;
      #1;
      if (lrck === 1'b1) break;
    end
    chk("lrck_first_rise_clks", 32'(n), 32'd1024);

    @(posedge sclk); t0 = $time;
    @(posedge sclk); chk("sclk_period_ns", 32'($time - t0), 32'd320);
    @(posedge mclk); t0 = $time;
    @(posedge mclk); chk("mclk_period_ns", 32'($time - t0), 32'd80);

    repeat (3 * 2048) @(negedge clk);

    adc_mode = 0;
    dac_mode = 0;
    repeat (4 * 2048) @(negedge clk);

    adc_mode = 2;
    dac_mode = 2;
    repeat (3 * 2048) @(negedge clk);

    adc_mode = 0;
    dac_mode = 0;
    n = 0;
    while (n < 4096 && !(lrck === 1'b1 && bitpos == 12)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4096) begin
      n_cmp++;
      n_err++;
      $display("FAIL midframe_wait: timeout, slot 12 of right half not reached");
    end
    rst = 1'b0;
    adc_q.delete();
    dac_q.delete();
    repeat (5) @(negedge clk);
    chk("midrst_adc_l",  32'(adc_l),         32'd0);
    chk("midrst_adc_r",  32'(adc_r),         32'd0);
    chk("midrst_sdata",  32'(dac_sdata),     32'd0);
    chk("midrst_lrck",   32'(lrck),          32'd0);
    chk("midrst_strobe", 32'(dac_rd_adc_wr), 32'd0);
    rst = 1'b1;
    model_start();
    repeat (3 * 2048 + 64) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pmod_i2s2.md
Name: pmod_i2s2

Overview:
- I2S master for the Pmod I2S2 codec board (CS4344 DAC, CS5343 ADC), running from the 100 MHz system clock.
- Generates MCLK, SCLK and LRCK from one free-running counter.
- Serialises a 24-bit stereo DAC sample pair and deserialises a 24-bit stereo ADC pair once per frame.
- Issues a one-cycle frame strobe so user logic (e.g. loopback) can exchange samples.

Parameters:
- DATA_W, 24, sample width per channel; fixed, not user-tunable.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-low reset (0 = reset)
- mclk  out  1  codec master clock = clk/8 (12.5 MHz)
- lrck  out  1  word select, 0 = left, 1 = right; clk/2048 (48.828 kHz)
- sclk  out  1  serial bit clock = clk/32 (3.125 MHz, 64 x fs)
- dac_l  in  24  left sample to transmit, two's complement
- dac_r  in  24  right sample to transmit
- dac_sdata  out  1  serial data to DAC
- adc_sdata  in  1  serial data from ADC
- adc_l  out  24  last received left sample
- adc_r  out  24  last received right sample
- dac_rd_adc_wr  out  1  one-clk frame strobe

Behaviour:
- Counter: 11-bit cnt, +1 every clk, wraps 2047->0; cnt=0 on reset.
- Clock outputs: mclk=cnt[2], sclk=cnt[4], lrck=cnt[10], driven straight from flop bits (glitch-free).
- Slot timing: slot index s=cnt[9:5], 0..31 per half-frame. Each slot starts at cnt[4:0]=0 with sclk falling; sclk rises at cnt[4:0]=16. lrck toggles together with an sclk falling edge at slot 0.
- Slot allocation (standard I2S, one-bit delay):
  - slot 0: delay bit.
  - slots 1..24: MSB..LSB.
  - slots 25..31: don't-care on input; DAC drives 0.
- DAC path:
  - dac_sdata is a register updated on the clk edge where cnt[4:0]=31 rolls to 0, so it changes with sclk falling.
  - Value for slot s in 1..24 = latched_sample[24-s]; otherwise 0.
  - Left half transmits latched_l, right half latched_r.
- ADC path:
  - On the clk edge where current cnt[4:0]=16 (sclk high one clk), adc_sdata is sampled into bit 24-s of the current channel's capture register, for s in 1..24.
  - Slots 0 and 25..31 are ignored.
- Frame strobe:
  - dac_rd_adc_wr=1 exactly when cnt=2047, else 0.
  - On that cycle's edge: adc_l<=capture_l, adc_r<=capture_r, latched_l<=dac_l, latched_r<=dac_r.
  - dac_l/dac_r must be valid during the strobe cycle; they are ignored at all other times.
- Latency:
  - An ADC frame received in frame N appears on adc_l/adc_r at the end of frame N.
  - DAC inputs sampled at the end of frame N are transmitted in frame N+1.
- Reset values: cnt, mclk, sclk, lrck, dac_sdata, adc_l, adc_r, capture and latched registers, and dac_rd_adc_wr are all 0.
  - The first frame after reset transmits zeros.
  - Reset asserted mid-frame aborts the frame; no partial adc_l/adc_r update.
- No handshake or back-pressure; fixed timing.

Decomposition:
- Package pmod_i2s2_pkg: DATA_W=24, CNT_W=11, bit positions MCLK_BIT=2, SCLK_BIT=4, LRCK_BIT=10, SLOT_MSB=9, SLOT_LSB=5, FIRST_DATA_SLOT=1, LAST_DATA_SLOT=24, FRAME_LAST=2047.
- One natural sub-module, pmod_i2s2_clkgen: counter plus mclk/sclk/lrck and the slot/phase decode (sample_en, shift_en, frame_end).

Test Plan:
- Reset: rst=0 for 10 cycles, then release -> all outputs 0 during reset; cnt starts at 0; lrck first rises 1024 clks after release; sclk period 320 ns; mclk period 80 ns.
- ADC capture: drive I2S left=0x555555, right=0x123456 (MSB on the second sclk falling edge after each lrck edge) -> at the next strobe adc_l=0x555555, adc_r=0x123456.
- DAC serialisation: dac_l=0xFFFFFF, dac_r=0x000000 held -> in the second frame dac_sdata=1 for exactly slots 1..24 of the left half, 0 in slot 0, slots 25..31 and the whole right half.
- Strobe: dac_rd_adc_wr high exactly 1 clk every 2048 clks, coincident with cnt=2047; dac_l changed outside that cycle is not transmitted.
- Loopback: tie adc_l->dac_l and adc_r->dac_r, feed ADC 0xA5A5A5/0x5A5A5A -> the same bit pattern appears on dac_sdata one frame later.
- Mid-frame reset: assert rst at slot 12 of the right half -> adc_l/adc_r go to 0; after release, the next full frame captures correctly.
